// File: rtl/mha_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mha_tile_sched
//  Purpose  : Tile-level scheduler for multi-head attention on a systolic
//             array. For each head h and row tile r it issues the Q*K^T
//             column-tile jobs (skipping fully masked tiles in causal mode),
//             one softmax over the row tile, then the S*V column-tile jobs,
//             handing every S*V result tile to a downstream consumer.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    I_CLK, I_ASYN_RST          clock (rising edge), async active-high reset
//    I_SYNC_CLR                 synchronous abort back to IDLE
//    I_ATTN_START, I_CAUSAL     run request (IDLE only), causal mode flag
//    O_SA_CLEARN                active-low accumulator clear for the array
//    O_SA_START/OP/HEAD/ROW_T/COL_T, I_SA_VLD
//                               array job issue (OP 0=Q*K^T, 1=S*V) and done
//    O_SM_START/HEAD/ROW_T/CAUSAL, I_SM_DONE
//                               softmax request and completion
//    O_TILE_VLD/HEAD/ROW_T/COL_T, I_TILE_RDY
//                               output tile handshake
//    O_BUSY, O_DONE             not idle, end-of-run pulse
// ============================================================================
module mha_tile_sched #(
  parameter int SA_R  = 16,
  parameter int SA_C  = 16,
  parameter int DIM   = 32,
  parameter int D_K   = 16,
  parameter int H_NUM = 2,
  localparam int RT   = DIM / SA_R,
  localparam int KT   = DIM / SA_C,
  localparam int VT   = D_K / SA_C,
  localparam int HW   = (H_NUM > 1) ? $clog2(H_NUM) : 1,
  localparam int MAXT = (RT > KT) ? ((RT > VT) ? RT : VT) : ((KT > VT) ? KT : VT),
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1
) (
  input  logic          I_CLK,
  input  logic          I_ASYN_RST,
  input  logic          I_SYNC_CLR,
  input  logic          I_ATTN_START,
  input  logic          I_CAUSAL,
  output logic          O_SA_CLEARN,
  output logic          O_SA_START,
  output logic          O_SA_OP,
  output logic [HW-1:0] O_SA_HEAD,
  output logic [TW-1:0] O_SA_ROW_T,
  output logic [TW-1:0] O_SA_COL_T,
  input  logic          I_SA_VLD,
  output logic          O_SM_START,
  output logic [HW-1:0] O_SM_HEAD,
  output logic [TW-1:0] O_SM_ROW_T,
  output logic          O_SM_CAUSAL,
  input  logic          I_SM_DONE,
  output logic          O_TILE_VLD,
  output logic [HW-1:0] O_TILE_HEAD,
  output logic [TW-1:0] O_TILE_ROW_T,
  output logic [TW-1:0] O_TILE_COL_T,
  input  logic          I_TILE_RDY,
  output logic          O_BUSY,
  output logic          O_DONE
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  generate
    if ((SA_R < 1) || (SA_C < 1) || ((DIM % SA_R) != 0) || ((DIM % SA_C) != 0)
        || (DIM < SA_R) || (DIM < SA_C)) begin : g_bad_dim
      $error("mha_tile_sched: DIM must be a positive multiple of SA_R and SA_C");
    end
    if (((D_K % SA_C) != 0) || (D_K < SA_C)) begin : g_bad_dk
      $error("mha_tile_sched: D_K must be a positive multiple of SA_C");
    end
    if (H_NUM < 1) begin : g_bad_heads
      $error("mha_tile_sched: H_NUM must be at least 1");
    end
  endgenerate

  // Last index of each loop, sized to the counter that is compared with it.
  localparam logic [HW-1:0] c_h_last  = HW'(H_NUM - 1);
  localparam logic [TW-1:0] c_rt_last = TW'(RT - 1);
  localparam logic [TW-1:0] c_kt_last = TW'(KT - 1);
  localparam logic [TW-1:0] c_vt_last = TW'(VT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_QK_CLR  = 3'd1,
    S_QK_WAIT = 3'd2,
    S_SM_WAIT = 3'd3,
    S_SV_CLR  = 3'd4,
    S_SV_WAIT = 3'd5,
    S_OUT     = 3'd6,
    S_DONE    = 3'd7
  } t_state;

  t_state        r_state;
  logic [HW-1:0] r_h;
  logic [TW-1:0] r_r;
  logic [TW-1:0] r_c;
  logic          r_causal;
  logic          r_op;
  logic          r_sa_clearn;
  logic          r_sa_start;
  logic          r_sm_start;
  logic          r_tile_vld;
  logic          r_busy;
  logic          r_done;

  // --------------------------------------------------------------------------
  // QK loop termination. The causal mask test is monotonic in c: once column
  // tile c+1 starts at or beyond the end of row tile r, every later column is
  // masked as well, so the current tile is the last one to issue.
  // --------------------------------------------------------------------------
  logic [31:0] w_next_col_base;
  logic [31:0] w_row_end;
  logic        w_next_masked;
  logic        w_qk_last;

  assign w_next_col_base = (32'(r_c) + 32'd1) * 32'(SA_C);
  assign w_row_end       = (32'(r_r) + 32'd1) * 32'(SA_R);
  assign w_next_masked   = r_causal && (w_next_col_base >= w_row_end);
  assign w_qk_last       = (r_c == c_kt_last) || w_next_masked;

  // Job completion is accepted only after the start cycle of a WAIT state;
  // r_sa_start is high exactly during that first cycle.
  logic w_sa_accept;
  assign w_sa_accept = I_SA_VLD && !r_sa_start;

  // --------------------------------------------------------------------------
  // Scheduler FSM. Every output is a flop updated here alongside the state,
  // so each output reflects the state it belongs to in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      r_state     <= S_IDLE;
      r_h         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_causal    <= 1'b0;
      r_op        <= 1'b0;
      r_sa_clearn <= 1'b1;
      r_sa_start  <= 1'b0;
      r_sm_start  <= 1'b0;
      r_tile_vld  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Pulses default low; only the transition that owns them raises them.
      r_sa_start <= 1'b0;
      r_sm_start <= 1'b0;
      r_done     <= 1'b0;

      if (I_SYNC_CLR) begin
        r_state     <= S_IDLE;
        r_h         <= '0;
        r_r         <= '0;
        r_c         <= '0;
        r_op        <= 1'b0;
        r_sa_clearn <= 1'b1;
        r_tile_vld  <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (I_ATTN_START) begin
              r_state     <= S_QK_CLR;
              r_causal    <= I_CAUSAL;
              r_h         <= '0;
              r_r         <= '0;
              r_c         <= '0;
              r_op        <= 1'b0;
              r_sa_clearn <= 1'b0;
              r_busy      <= 1'b1;
            end
          end

          S_QK_CLR: begin
            r_state     <= S_QK_WAIT;
            r_sa_clearn <= 1'b1;
            r_sa_start  <= 1'b1;
          end

          S_QK_WAIT: begin
            if (w_sa_accept) begin
              if (w_qk_last) begin
                r_state    <= S_SM_WAIT;
                r_sm_start <= 1'b1;
              end else begin
                r_state     <= S_QK_CLR;
                r_c         <= r_c + TW'(1);
                r_sa_clearn <= 1'b0;
              end
            end
          end

          S_SM_WAIT: begin
            if (I_SM_DONE) begin
              r_state     <= S_SV_CLR;
              r_c         <= '0;
              r_op        <= 1'b1;
              r_sa_clearn <= 1'b0;
            end
          end

          S_SV_CLR: begin
            r_state     <= S_SV_WAIT;
            r_sa_clearn <= 1'b1;
            r_sa_start  <= 1'b1;
          end

          S_SV_WAIT: begin
            if (w_sa_accept) begin
              r_state    <= S_OUT;
              r_tile_vld <= 1'b1;
            end
          end

          S_OUT: begin
            if (I_TILE_RDY) begin
              r_tile_vld <= 1'b0;
              if (r_c != c_vt_last) begin
                r_state     <= S_SV_CLR;
                r_c         <= r_c + TW'(1);
                r_sa_clearn <= 1'b0;
              end else if (r_r != c_rt_last) begin
                r_state     <= S_QK_CLR;
                r_r         <= r_r + TW'(1);
                r_c         <= '0;
                r_op        <= 1'b0;
                r_sa_clearn <= 1'b0;
              end else if (r_h != c_h_last) begin
                r_state     <= S_QK_CLR;
                r_h         <= r_h + HW'(1);
                r_r         <= '0;
                r_c         <= '0;
                r_op        <= 1'b0;
                r_sa_clearn <= 1'b0;
              end else begin
                // All loops exhausted: wrap counters for the next run.
                r_state <= S_DONE;
                r_h     <= '0;
                r_r     <= '0;
                r_c     <= '0;
                r_op    <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end

          S_DONE: begin
            // A start request here is deliberately dropped.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end

          default: begin
            r_state     <= S_IDLE;
            r_sa_clearn <= 1'b1;
            r_tile_vld  <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping. The loop counters only move on the transition that ends
  // the job or tile they describe, so they double as the index outputs.
  // --------------------------------------------------------------------------
  assign O_SA_CLEARN  = r_sa_clearn;
  assign O_SA_START   = r_sa_start;
  assign O_SA_OP      = r_op;
  assign O_SA_HEAD    = r_h;
  assign O_SA_ROW_T   = r_r;
  assign O_SA_COL_T   = r_c;
  assign O_SM_START   = r_sm_start;
  assign O_SM_HEAD    = r_h;
  assign O_SM_ROW_T   = r_r;
  assign O_SM_CAUSAL  = r_causal;
  assign O_TILE_VLD   = r_tile_vld;
  assign O_TILE_HEAD  = r_h;
  assign O_TILE_ROW_T = r_r;
  assign O_TILE_COL_T = r_c;
  assign O_BUSY       = r_busy;
  assign O_DONE       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mha_tile_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mha_tile_sched
//  Purpose  : Self-checking bench for mha_tile_sched. Two instances: the
//             default geometry (A) and a one-head, two-SV-tile geometry (B).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mha_tile_sched;

  // Instance A: default parameters
  localparam int A_SA_R = 16, A_SA_C = 16, A_DIM = 32, A_DK = 16, A_H = 2;
  localparam int A_RT = A_DIM / A_SA_R, A_KT = A_DIM / A_SA_C, A_VT = A_DK / A_SA_C;
  // Instance B: single head, DIM=16, D_K=32
  localparam int B_SA_R = 16, B_SA_C = 16, B_DIM = 16, B_DK = 32, B_H = 1;
  localparam int B_RT = B_DIM / B_SA_R, B_KT = B_DIM / B_SA_C, B_VT = B_DK / B_SA_C;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A signals
  logic       a_clr, a_start, a_causal;
  logic       a_sa_vld = 1'b0, a_sm_done = 1'b0, a_tile_rdy = 1'b0;
  logic       a_sa_clearn, a_sa_start, a_sa_op, a_sm_start, a_sm_causal;
  logic       a_tile_vld, a_busy, a_done;
  logic [0:0] a_sa_head, a_sa_row_t, a_sa_col_t, a_sm_head, a_sm_row_t;
  logic [0:0] a_tile_head, a_tile_row_t, a_tile_col_t;

  // DUT B signals
  logic       b_clr, b_start, b_causal;
  logic       b_sa_vld = 1'b0, b_sm_done = 1'b0, b_tile_rdy = 1'b0;
  logic       b_sa_clearn, b_sa_start, b_sa_op, b_sm_start, b_sm_causal;
  logic       b_tile_vld, b_busy, b_done;
  logic [0:0] b_sa_head, b_sa_row_t, b_sa_col_t, b_sm_head, b_sm_row_t;
  logic [0:0] b_tile_head, b_tile_row_t, b_tile_col_t;

  mha_tile_sched #(.SA_R(A_SA_R), .SA_C(A_SA_C), .DIM(A_DIM), .D_K(A_DK), .H_NUM(A_H)) u_dut_a (
    .I_CLK(clk), .I_ASYN_RST(rst), .I_SYNC_CLR(a_clr), .I_ATTN_START(a_start),
    .I_CAUSAL(a_causal), .O_SA_CLEARN(a_sa_clearn), .O_SA_START(a_sa_start),
    .O_SA_OP(a_sa_op), .O_SA_HEAD(a_sa_head), .O_SA_ROW_T(a_sa_row_t),
    .O_SA_COL_T(a_sa_col_t), .I_SA_VLD(a_sa_vld), .O_SM_START(a_sm_start),
    .O_SM_HEAD(a_sm_head), .O_SM_ROW_T(a_sm_row_t), .O_SM_CAUSAL(a_sm_causal),
    .I_SM_DONE(a_sm_done), .O_TILE_VLD(a_tile_vld), .O_TILE_HEAD(a_tile_head),
    .O_TILE_ROW_T(a_tile_row_t), .O_TILE_COL_T(a_tile_col_t), .I_TILE_RDY(a_tile_rdy),
    .O_BUSY(a_busy), .O_DONE(a_done)
  );

  mha_tile_sched #(.SA_R(B_SA_R), .SA_C(B_SA_C), .DIM(B_DIM), .D_K(B_DK), .H_NUM(B_H)) u_dut_b (
    .I_CLK(clk), .I_ASYN_RST(rst), .I_SYNC_CLR(b_clr), .I_ATTN_START(b_start),
    .I_CAUSAL(b_causal), .O_SA_CLEARN(b_sa_clearn), .O_SA_START(b_sa_start),
    .O_SA_OP(b_sa_op), .O_SA_HEAD(b_sa_head), .O_SA_ROW_T(b_sa_row_t),
    .O_SA_COL_T(b_sa_col_t), .I_SA_VLD(b_sa_vld), .O_SM_START(b_sm_start),
    .O_SM_HEAD(b_sm_head), .O_SM_ROW_T(b_sm_row_t), .O_SM_CAUSAL(b_sm_causal),
    .I_SM_DONE(b_sm_done), .O_TILE_VLD(b_tile_vld), .O_TILE_HEAD(b_tile_head),
    .O_TILE_ROW_T(b_tile_row_t), .O_TILE_COL_T(b_tile_col_t), .I_TILE_RDY(b_tile_rdy),
    .O_BUSY(b_busy), .O_DONE(b_done)
  );

  // Bookkeeping
  int n_cmp = 0;
  int n_err = 0;
  int exp_sa[$], exp_sm[$], exp_tile[$];
  int obs_sa[$], obs_sm[$], obs_tile[$];
  int n_sa_start = 0, n_sm_start = 0, n_sv_start = 0, n_clr = 0, n_done = 0;
  int d0, clr0;

  // Responder controls (written only by the main initial block)
  int a_lat_min = 3, a_lat_max = 3, a_rdy_mode = 0;
  bit a_sa_en = 1'b1, a_sm_en = 1'b1, a_force_sa = 1'b0, a_force_sm = 1'b0;
  int a_sa_cnt = 0, a_sm_cnt = 0, b_sa_cnt = 0, b_sm_cnt = 0;

  function automatic int enc(input int op, input int h, input int r, input int c);
    return op * 4096 + h * 256 + r * 16 + c;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference schedule: nested loops straight from the attention tiling rules.
  task automatic build_model(input int hn, input int rt, input int kt, input int vt,
                             input int sar, input int sac, input bit causal);
    exp_sa.delete(); exp_sm.delete(); exp_tile.delete();
    for (int h = 0; h < hn; h++) begin
      for (int r = 0; r < rt; r++) begin
        for (int c = 0; c < kt; c++)
          if (!causal || (c * sac < (r + 1) * sar)) exp_sa.push_back(enc(0, h, r, c));
        exp_sm.push_back(enc(int'(causal), h, r, 0));
        for (int c = 0; c < vt; c++) begin
          exp_sa.push_back(enc(1, h, r, c));
          exp_tile.push_back(enc(0, h, r, c));
        end
      end
    end
  endtask

  // Monitor and responders for both instances, all on the falling edge.
  always @(negedge clk) begin
    if (a_sa_start) begin
      obs_sa.push_back(enc(int'(a_sa_op), int'(a_sa_head), int'(a_sa_row_t), int'(a_sa_col_t)));
      n_sa_start++;
      if (a_sa_op) n_sv_start++;
    end
    if (b_sa_start) begin
      obs_sa.push_back(enc(int'(b_sa_op), int'(b_sa_head), int'(b_sa_row_t), int'(b_sa_col_t)));
      n_sa_start++;
      if (b_sa_op) n_sv_start++;
    end
    if (a_sm_start) begin
      obs_sm.push_back(enc(int'(a_sm_causal), int'(a_sm_head), int'(a_sm_row_t), 0));
      n_sm_start++;
    end
    if (b_sm_start) begin
      obs_sm.push_back(enc(int'(b_sm_causal), int'(b_sm_head), int'(b_sm_row_t), 0));
      n_sm_start++;
    end
    if (!a_sa_clearn) n_clr++;
    if (!b_sa_clearn) n_clr++;
    if (a_done) n_done++;
    if (b_done) n_done++;

    if (rst) begin
      a_sa_cnt = 0; a_sm_cnt = 0; b_sa_cnt = 0; b_sm_cnt = 0;
    end

    a_sa_vld = a_force_sa;
    if (a_sa_start && a_sa_en) a_sa_cnt = int'($urandom_range(a_lat_max, a_lat_min));
    else if (a_sa_cnt > 0) begin a_sa_cnt--; if (a_sa_cnt == 0) a_sa_vld = 1'b1; end
    a_sm_done = a_force_sm;
    if (a_sm_start && a_sm_en) a_sm_cnt = int'($urandom_range(a_lat_max, a_lat_min));
    else if (a_sm_cnt > 0) begin a_sm_cnt--; if (a_sm_cnt == 0) a_sm_done = 1'b1; end
    case (a_rdy_mode)
      0:       a_tile_rdy = 1'b1;
      1:       a_tile_rdy = ($urandom_range(1, 0) == 1);
      default: a_tile_rdy = 1'b0;
    endcase
    if (a_tile_vld && a_tile_rdy)
      obs_tile.push_back(enc(0, int'(a_tile_head), int'(a_tile_row_t), int'(a_tile_col_t)));

    b_sa_vld = 1'b0;
    if (b_sa_start) b_sa_cnt = 2;
    else if (b_sa_cnt > 0) begin b_sa_cnt--; if (b_sa_cnt == 0) b_sa_vld = 1'b1; end
    b_sm_done = 1'b0;
    if (b_sm_start) b_sm_cnt = 2;
    else if (b_sm_cnt > 0) begin b_sm_cnt--; if (b_sm_cnt == 0) b_sm_done = 1'b1; end
    b_tile_rdy = ($urandom_range(1, 0) == 1);
    if (b_tile_vld && b_tile_rdy)
      obs_tile.push_back(enc(0, int'(b_tile_head), int'(b_tile_row_t), int'(b_tile_col_t)));
  end

  task automatic compare_queues(input string tag);
    check_val({tag, " sa count"}, obs_sa.size(), exp_sa.size());
    foreach (exp_sa[i]) if (i < obs_sa.size()) check_val($sformatf("%s sa[%0d]", tag, i), obs_sa[i], exp_sa[i]);
    check_val({tag, " sm count"}, obs_sm.size(), exp_sm.size());
    foreach (exp_sm[i]) if (i < obs_sm.size()) check_val($sformatf("%s sm[%0d]", tag, i), obs_sm[i], exp_sm[i]);
    check_val({tag, " tile count"}, obs_tile.size(), exp_tile.size());
    foreach (exp_tile[i]) if (i < obs_tile.size()) check_val($sformatf("%s tile[%0d]", tag, i), obs_tile[i], exp_tile[i]);
  endtask

  task automatic start_run(input int sel, input bit causal);
    obs_sa.delete(); obs_sm.delete(); obs_tile.delete();
    if (sel == 0) build_model(A_H, A_RT, A_KT, A_VT, A_SA_R, A_SA_C, causal);
    else          build_model(B_H, B_RT, B_KT, B_VT, B_SA_R, B_SA_C, causal);
    d0 = n_done;
    clr0 = n_clr;
    @(posedge clk); #1;
    if (sel == 0) begin a_causal = causal; a_start = 1'b1; end
    else          begin b_causal = causal; b_start = 1'b1; end
    @(posedge clk); #1;
    a_start = 1'b0; b_start = 1'b0;
    // Flip the causal input: the scheduler must use the value latched at start.
    a_causal = ~causal; b_causal = ~causal;
  endtask

  task automatic finish_run(input int sel, input string tag);
    int cyc;
    cyc = 0;
    while (n_done == d0 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    check_val({tag, " done pulse"}, n_done - d0, 1);
    check_val({tag, " idle after done"}, (sel == 0) ? a_busy : b_busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, " single done"}, n_done - d0, 1);
    check_val({tag, " clear cycles"}, n_clr - clr0, exp_sa.size());
    compare_queues(tag);
  endtask

  initial begin
    int cyc, s0, sv0, op0_cnt;
    logic [2:0] idx;
    bit stable;
    rst = 1'b1;
    a_clr = 1'b0; a_start = 1'b0; a_causal = 1'b0;
    b_clr = 1'b0; b_start = 1'b0; b_causal = 1'b0;

    // Reset state, with a start request that must be ignored under reset
    repeat (2) @(posedge clk);
    #1; a_start = 1'b1;
    @(posedge clk); #1; a_start = 1'b0;
    check_val("rst clearn", a_sa_clearn, 1'b1);
    check_val("rst busy", a_busy, 1'b0);
    check_val("rst sa_start", a_sa_start, 1'b0);
    check_val("rst tile_vld", a_tile_vld, 1'b0);
    check_val("rst done", a_done, 1'b0);
    check_val("rst sm_causal", a_sm_causal, 1'b0);
    check_val("rst b clearn", b_sa_clearn, 1'b1);
    check_val("rst b busy", b_busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Non-causal run, 3-cycle responders, consumer always ready
    start_run(0, 1'b0);
    finish_run(0, "base");
    op0_cnt = 0;
    foreach (obs_sa[i]) if (obs_sa[i] < 4096) op0_cnt++;
    check_val("base qk jobs", op0_cnt, 8);
    check_val("base sv jobs", obs_sa.size() - op0_cnt, 4);

    // Causal run
    start_run(0, 1'b1);
    finish_run(0, "causal");
    check_val("causal job total", obs_sa.size(), 10);

    // Consumer stall on the first tile
    a_rdy_mode = 2;
    start_run(0, 1'b0);
    cyc = 0;
    while (!a_tile_vld && cyc < 500) begin @(posedge clk); #1; cyc++; end
    check_val("stall tile seen", a_tile_vld, 1'b1);
    idx = {a_tile_head, a_tile_row_t, a_tile_col_t};
    s0 = n_sa_start;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!a_tile_vld || ({a_tile_head, a_tile_row_t, a_tile_col_t} != idx)) stable = 1'b0;
    end
    check_val("stall held", stable, 1'b1);
    check_val("stall no job", n_sa_start - s0, 0);
    a_rdy_mode = 0;
    finish_run(0, "stall");

    // Completion strobes while idle must be ignored
    s0 = n_sa_start;
    a_force_sa = 1'b1; a_force_sm = 1'b1;
    @(posedge clk); #1;
    a_force_sa = 1'b0; a_force_sm = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("idle vld busy", a_busy, 1'b0);
    check_val("idle vld no job", n_sa_start - s0, 0);

    // Array completion while waiting on softmax must be ignored
    a_sm_en = 1'b0;
    start_run(0, 1'b0);
    cyc = 0;
    while (obs_sm.size() == 0 && cyc < 500) begin @(posedge clk); #1; cyc++; end
    check_val("smwait reached", obs_sm.size(), 1);
    s0 = n_sa_start;
    repeat (2) @(posedge clk);
    #1; a_force_sa = 1'b1;
    @(posedge clk); #1; a_force_sa = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("smwait busy", a_busy, 1'b1);
    check_val("smwait no job", n_sa_start - s0, 0);
    a_force_sm = 1'b1;
    @(posedge clk); #1;
    a_force_sm = 1'b0; a_sm_en = 1'b1;
    finish_run(0, "smwait");

    // Synchronous abort in QK_WAIT
    start_run(0, 1'b0);
    s0 = n_sa_start - obs_sa.size();
    cyc = 0;
    while (obs_sa.size() == 0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    check_val("sclr busy", a_busy, 1'b0);
    check_val("sclr clearn", a_sa_clearn, 1'b1);
    check_val("sclr sa_start", a_sa_start, 1'b0);
    check_val("sclr tile_vld", a_tile_vld, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_val("sclr no done", n_done - d0, 0);
    check_val("sclr stays idle", a_busy, 1'b0);

    // Asynchronous reset during an S*V job
    start_run(0, 1'b0);
    sv0 = n_sv_start;
    cyc = 0;
    while (n_sv_start == sv0 && cyc < 500) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_val("arst busy", a_busy, 1'b0);
    check_val("arst clearn", a_sa_clearn, 1'b1);
    check_val("arst op", a_sa_op, 1'b0);
    check_val("arst sa_start", a_sa_start, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_val("arst no done", n_done - d0, 0);
    start_run(0, 1'b0);
    finish_run(0, "fresh");

    // Randomized runs on A
    a_lat_min = 1; a_lat_max = 5; a_rdy_mode = 1;
    for (int k = 0; k < 4; k++) begin
      start_run(0, 1'($urandom_range(1, 0)));
      finish_run(0, $sformatf("rand%0d", k));
    end
    a_rdy_mode = 0;

    // Single-head geometry with two S*V tiles
    start_run(1, 1'b0);
    finish_run(1, "geomB");
    for (int k = 0; k < 2; k++) begin
      start_run(1, 1'($urandom_range(1, 0)));
      finish_run(1, $sformatf("geomB rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mha_tile_sched.md
MHA_TILE_SCHED -- requirements
Module: mha_tile_sched

Interface
REQ-001 SHALL have parameter SA_R, default 16: systolic array rows, which is also the row-tile height.
REQ-002 SHALL have parameter SA_C, default 16: systolic array columns, which is also the column-tile width.
REQ-003 SHALL have parameter DIM, default 32: sequence length; DIM%SA_R==0 and DIM%SA_C==0, otherwise elaboration fails.
REQ-004 SHALL have parameter D_K, default 16: per-head column count; D_K%SA_C==0.
REQ-005 SHALL have parameter H_NUM, default 2: number of heads, at least 1.
REQ-006 SHALL define derived localparams:
- RT=DIM/SA_R, KT=DIM/SA_C, VT=D_K/SA_C.
- HW=max(1,clog2(H_NUM)).
- TW=max(1,clog2(max(RT,KT,VT))).
REQ-007 Ports, clock and reset first:
- I_CLK  in  1  single clock, rising edge.
- I_ASYN_RST  in  1  asynchronous, active-high reset.
- I_SYNC_CLR  in  1  synchronous abort; return to IDLE.
- I_ATTN_START  in  1  start request; sampled in IDLE only.
- I_CAUSAL  in  1  causal mode; latched at start.
- O_SA_CLEARN  out  1  active-low clear to the systolic array.
- O_SA_START  out  1  one-cycle job start pulse.
- O_SA_OP  out  1  0=Q*K^T, 1=S*V.
- O_SA_HEAD  out  HW  head index of the current job.
- O_SA_ROW_T  out  TW  row-tile index of the current job.
- O_SA_COL_T  out  TW  column-tile index of the current job.
- I_SA_VLD  in  1  array job complete.
- O_SM_START  out  1  one-cycle softmax start pulse.
- O_SM_HEAD  out  HW  head index for softmax.
- O_SM_ROW_T  out  TW  row-tile index for softmax.
- O_SM_CAUSAL  out  1  latched causal flag for softmax.
- I_SM_DONE  in  1  softmax complete.
- O_TILE_VLD  out  1  output tile valid.
- O_TILE_HEAD  out  HW  head index of the output tile.
- O_TILE_ROW_T  out  TW  row-tile index of the output tile.
- O_TILE_COL_T  out  TW  column-tile index of the output tile.
- I_TILE_RDY  in  1  consumer ready.
- O_BUSY  out  1  not IDLE.
- O_DONE  out  1  one-cycle pulse when all heads are finished.

Function
REQ-008 SHALL implement FSM states IDLE, QK_CLR, QK_WAIT, SM_WAIT, SV_CLR, SV_WAIT, OUT, DONE.
REQ-009 SHALL iterate loops in this order: head h 0..H_NUM-1 (outer), then row tile r 0..RT-1; per (h,r), QK column tiles c 0..KT-1, then one softmax, then SV column tiles c 0..VT-1.
REQ-010 IDLE with I_ATTN_START=1 SHALL go to QK_CLR next cycle and latch I_CAUSAL; h, r and c SHALL reset to 0.
REQ-011 *_CLR states SHALL last exactly one cycle with O_SA_CLEARN=0; O_SA_CLEARN=1 in every other state.
REQ-012 The first cycle of QK_WAIT/SV_WAIT SHALL drive O_SA_START=1 for exactly one cycle; O_SA_OP/HEAD/ROW_T/COL_T SHALL be stable from the CLR cycle until I_SA_VLD is accepted.
REQ-013 I_SA_VLD SHALL be honoured only in *_WAIT cycles after the START cycle; it SHALL be ignored in every other state.
REQ-014 In causal mode, QK tile c SHALL be skipped when c*SA_C >= (r+1)*SA_R, because that tile is fully masked; skipped tiles issue no job.
REQ-015 After the last issued QK tile completes, the FSM SHALL enter SM_WAIT, pulsing O_SM_START in its first cycle with O_SM_HEAD=h, O_SM_ROW_T=r, O_SM_CAUSAL=latched flag.
REQ-016 I_SM_DONE in SM_WAIT SHALL move the FSM to SV_CLR with c=0; I_SM_DONE in other states SHALL be ignored.
REQ-017 Each SV job completion SHALL move the FSM to OUT: O_TILE_VLD=1 with indices (h,r,c) held until the cycle I_TILE_RDY=1.
REQ-018 On that I_TILE_RDY cycle the FSM SHALL advance:
- next SV tile if c<VT-1,
- else next r (back to QK_CLR),
- else next h,
- else DONE.
REQ-019 DONE SHALL last one cycle with O_DONE=1, then go to IDLE; I_ATTN_START asserted during DONE SHALL be ignored.
REQ-020 I_SYNC_CLR=1 in any state SHALL force IDLE next cycle with all pulses and valids deasserted; it has priority over every other input, including I_ATTN_START.
REQ-021 O_BUSY SHALL be 1 in every state except IDLE.
REQ-022 All outputs SHALL be registered; counters SHALL never exceed their limits and SHALL wrap to 0 when the enclosing loop advances.

Reset
REQ-023 I_ASYN_RST=1 SHALL immediately force IDLE, h=r=c=0, causal flag 0, O_SA_CLEARN=1 and all other outputs 0; this SHALL hold regardless of the clock.
REQ-024 After deassertion, the first rising edge with I_ATTN_START=1 SHALL start a run; asserting reset mid-run SHALL abandon the run with no O_DONE.

Verification
REQ-025 Default parameters, I_CAUSAL=0, SA and softmax responders 3 cycles late, I_TILE_RDY tied to 1 -> exactly 12 O_SA_START (8 op 0, 4 op 1), 4 O_SM_START and 4 tiles (h,r,0), in order (0,0),(0,1),(1,0),(1,1), followed by one O_DONE.
REQ-026 Same run with I_CAUSAL=1 -> 10 O_SA_START; tile (r=0,c=1) is never issued for either head; O_SM_CAUSAL=1 on all 4 softmax starts.
REQ-027 I_TILE_RDY held 0 for 20 cycles at the first tile -> O_TILE_VLD and indices are stable for 20 cycles and no new O_SA_START occurs.
REQ-028 I_SA_VLD pulsed in IDLE and in SM_WAIT -> no state change and no extra job.
REQ-029 I_SYNC_CLR in QK_WAIT, then I_ASYN_RST asserted mid SV_WAIT on a second run -> IDLE next cycle in the first case and IDLE immediately in the second, O_DONE never asserted in either run, and a fresh start completes normally.
REQ-030 H_NUM=1, DIM=16, D_K=32 -> 1 QK job, 1 softmax, 2 SV jobs with tiles (0,0,0) then (0,0,1), then O_DONE.
